hyper_tx_sequencer: RTL

//  Fills the HyperBus TX output FIFO, which carries 18-bit words {strb[1:0], data[15:0]}.

---
 rtl/hyper_pkg.sv | 29 ++
 rtl/hyper_tx_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/hyper_pkg.sv
// HyperBus TX sequencer types: command descriptor, FSM states and CA packing.
// Shared by the sequencer and anything that needs to build or inspect CA words.
package hyper_pkg;

    localparam int          HYPER_LEN_W = 8;
    localparam int          CA_WORDS    = 3;
    localparam logic [1:0]  CA_STRB     = 2'b11;

    typedef struct packed {
        logic [31:0]            addr;
        logic [HYPER_LEN_W-1:0] len;
        logic                   write;
        logic                   reg_space;
    } hyper_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CA0,
        CA1,
        CA2,
        DATA
    } tx_state_e;

    // Linear burst always; the low address bits go in the bottom CA word.
    function automatic logic [47:0] ca_encode(input hyper_cmd_t c);
        return {~c.write, c.reg_space, 1'b1, c.addr[31:3], 13'b0, c.addr[2:0]};
    endfunction

endpackage

// File: rtl/hyper_tx_sequencer.sv
// Sole writer of the HyperBus TX FIFO: three CA words per descriptor, then write payload.
// Latency: CA0 one cycle after cmd accept; payload is a zero-latency pass-through.
// Backpressure: fifo_ready_i stalls CA words (held stable) and gates wready_o in DATA.
module hyper_tx_sequencer
    import hyper_pkg::*;
#(
    parameter int LEN_W      = HYPER_LEN_W,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [31:0]           cmd_addr_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic                  cmd_write_i,
    input  logic                  cmd_reg_i,
    input  logic [15:0]           wdata_i,
    input  logic [1:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_valid_o,
    input  logic                  fifo_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    tx_state_e                    state_q, state_d;
    hyper_cmd_t                   cmd_q, cmd_d;
    logic [LEN_W-1:0]             cnt_q, cnt_d;
    logic [CA_WORDS-1:0][15:0]    ca_words;

    // cmd_q only changes in IDLE, so CA words are stable across any stall.
    assign ca_words = ca_encode(cmd_q);
    assign busy_o   = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        cmd_ready_o  = 1'b0;
        wready_o     = 1'b0;
        fifo_valid_o = 1'b0;
        fifo_data_o  = '0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    cmd_d.addr      = cmd_addr_i;
                    cmd_d.len       = HYPER_LEN_W'(cmd_len_i);
                    cmd_d.write     = cmd_write_i;
                    cmd_d.reg_space = cmd_reg_i;
                    state_d         = CA0;
                end
            end
            CA0: begin
                fifo_valid_o = 1'b1;
                fifo_data_o  = {CA_STRB, ca_words[CA_WORDS-1]};
                if (fifo_ready_i) state_d = CA1;
            end
            CA1: begin
                fifo_valid_o = 1'b1;
                fifo_data_o  = {CA_STRB, ca_words[CA_WORDS-2]};
                if (fifo_ready_i) state_d = CA2;
            end
            CA2: begin
                fifo_valid_o = 1'b1;
                fifo_data_o  = {CA_STRB, ca_words[CA_WORDS-3]};
                if (fifo_ready_i) begin
                    if (!cmd_q.write) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Register writes carry exactly one beat whatever len says.
                        cnt_d   = cmd_q.reg_space ? '0 : LEN_W'(cmd_q.len);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                wready_o     = fifo_ready_i;
                fifo_valid_o = wvalid_i;
                fifo_data_o  = {wstrb_i, wdata_i};
                if (wvalid_i && fifo_ready_i) begin
                    if (cnt_q == '0) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle abandons the transaction, so it must not report completion.
        if (rst_i) done_o = 1'b0;
    end

endmodule
